// File: rtl/dds_nco_multi.sv
// Multi-channel NCO: per-channel phase accumulators sharing one quarter-wave sine table,
// one sin/cos sample per cycle in round-robin order on an AXI-stream output.
module dds_nco_multi #(
    parameter int NUM_CH   = 4,
    parameter int ACC_DW   = 32,
    parameter int PHASE_DW = 16,
    parameter int OUT_DW   = 16,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sync,
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_DW-1:0]   cfg_ftw,
    input  logic [PHASE_DW-1:0] cfg_poff,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [OUT_DW-1:0]   m_axis_sin_tdata,
    output logic [OUT_DW-1:0]   m_axis_cos_tdata,
    output logic [CH_W-1:0]     m_axis_tuser,
    output logic                m_axis_tlast
);
    localparam int LUT_AW = PHASE_DW - 2;
    localparam int DEPTH  = 2 ** LUT_AW;
    localparam logic [OUT_DW-1:0] FS = OUT_DW'(2 ** (OUT_DW - 1) - 1);

    // Table is generated at elaboration: round(FS * sin(2*pi*k / 2**PHASE_DW)) for the first quadrant.
    function automatic logic [OUT_DW-1:0] lut_val(input int k);
        real a;
        a = 2.0 * 3.141592653589793 * real'(k) / real'(4 * DEPTH);
        return OUT_DW'($rtoi(real'(2 ** (OUT_DW - 1) - 1) * $sin(a) + 0.5));
    endfunction

    logic [OUT_DW-1:0] lut [DEPTH];
    for (genvar i = 0; i < DEPTH; i++) begin : g_lut
        localparam logic [OUT_DW-1:0] V = lut_val(i);
        assign lut[i] = V;
    end

    logic cfg_ok;
    if (NUM_CH == 2 ** CH_W) begin : g_full
        assign cfg_ok = 1'b1;
    end else begin : g_part
        assign cfg_ok = (cfg_ch < CH_W'(NUM_CH));
    end

    logic [ACC_DW-1:0]   acc_q [NUM_CH], acc_d [NUM_CH];
    logic [ACC_DW-1:0]   ftw_q [NUM_CH], ftw_d [NUM_CH];
    logic [PHASE_DW-1:0] poff_q [NUM_CH], poff_d [NUM_CH];
    logic [CH_W-1:0]     cnt_q, cnt_d;

    // vld_q[0] issue stage ... vld_q[4] output register
    logic [4:0]          vld_q;
    logic [PHASE_DW-1:0] ph1_q;
    logic [CH_W-1:0]     ch1_q, ch2_q, ch3_q, ch4_q, tuser_q;
    logic [1:0]          q2_q, q3_q, q4_q;
    logic [LUT_AW-1:0]   sidx2_q, cidx2_q;
    logic                smax2_q, cmax2_q, smax3_q, cmax3_q;
    logic [OUT_DW-1:0]   srom3_q, crom3_q, smag4_q, cmag4_q, sin_q, cos_q;
    logic                tlast_q;

    logic                adv, issue;
    logic [PHASE_DW-1:0] phase_d;
    logic [1:0]          q1;
    logic [LUT_AW-1:0]   f1;

    assign adv     = !vld_q[4] || m_axis_tready;
    assign issue   = adv && en && !sync;
    assign phase_d = acc_q[cnt_q][ACC_DW-1 -: PHASE_DW] + poff_q[cnt_q];
    assign q1      = ph1_q[PHASE_DW-1 -: 2];
    assign f1      = ph1_q[LUT_AW-1:0];

    // Issue uses the old ftw/poff; a same-cycle config write only lands at the edge.
    always_comb begin
        acc_d  = acc_q;
        ftw_d  = ftw_q;
        poff_d = poff_q;
        cnt_d  = cnt_q;
        if (sync) begin
            acc_d = '{default: '0};
            cnt_d = '0;
        end else if (issue) begin
            acc_d[cnt_q] = acc_q[cnt_q] + ftw_q[cnt_q];
            cnt_d = (cnt_q == CH_W'(NUM_CH - 1)) ? '0 : cnt_q + 1'b1;
        end
        if (cfg_valid && cfg_ok) begin
            ftw_d[cfg_ch]  = cfg_ftw;
            poff_d[cfg_ch] = cfg_poff;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '{default: '0};
            ftw_q   <= '{default: '0};
            poff_q  <= '{default: '0};
            cnt_q   <= '0;
            vld_q   <= '0;
            ph1_q   <= '0;
            ch1_q   <= '0;
            ch2_q   <= '0;
            ch3_q   <= '0;
            ch4_q   <= '0;
            tuser_q <= '0;
            q2_q    <= '0;
            q3_q    <= '0;
            q4_q    <= '0;
            sidx2_q <= '0;
            cidx2_q <= '0;
            smax2_q <= 1'b0;
            cmax2_q <= 1'b0;
            smax3_q <= 1'b0;
            cmax3_q <= 1'b0;
            srom3_q <= '0;
            crom3_q <= '0;
            smag4_q <= '0;
            cmag4_q <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            tlast_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ftw_q  <= ftw_d;
            poff_q <= poff_d;
            cnt_q  <= cnt_d;
            if (adv) begin
                vld_q   <= {vld_q[3:0], issue};
                ph1_q   <= phase_d;
                ch1_q   <= cnt_q;
                // index + quadrant; the table has no entry for the exact quarter point
                ch2_q   <= ch1_q;
                q2_q    <= q1;
                sidx2_q <= q1[0] ? LUT_AW'(0) - f1 : f1;
                cidx2_q <= q1[0] ? f1 : LUT_AW'(0) - f1;
                smax2_q <= q1[0] && (f1 == '0);
                cmax2_q <= !q1[0] && (f1 == '0);
                // two-cycle table read: raw read, then registered magnitude
                ch3_q   <= ch2_q;
                q3_q    <= q2_q;
                smax3_q <= smax2_q;
                cmax3_q <= cmax2_q;
                srom3_q <= lut[sidx2_q];
                crom3_q <= lut[cidx2_q];
                ch4_q   <= ch3_q;
                q4_q    <= q3_q;
                smag4_q <= smax3_q ? FS : srom3_q;
                cmag4_q <= cmax3_q ? FS : crom3_q;
                tuser_q <= ch4_q;
                tlast_q <= (ch4_q == CH_W'(NUM_CH - 1));
                sin_q   <= q4_q[1] ? OUT_DW'(0) - smag4_q : smag4_q;
                cos_q   <= (q4_q[1] ^ q4_q[0]) ? OUT_DW'(0) - cmag4_q : cmag4_q;
            end
        end
    end

    assign m_axis_tvalid    = vld_q[4];
    assign m_axis_sin_tdata = sin_q;
    assign m_axis_cos_tdata = cos_q;
    assign m_axis_tuser     = tuser_q;
    assign m_axis_tlast     = tlast_q;
endmodule
